// File: rtl/complex_result_accumulator.sv
// Sums groups of complex results into wide signed accumulators and hands each group sum on over valid/ready.
// Define SATURATE_EN to clamp on overflow; otherwise the accumulators wrap modulo 2^ACC_W.
module complex_result_accumulator #(
  parameter int RES_W = 11,
  parameter int ACC_W = 16,
  parameter int LEN   = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*RES_W-1:0] in_result,
  input  logic               in_ovf_real,
  input  logic               in_ovf_imag,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_real,
  output logic [ACC_W-1:0]   out_imag,
  output logic               out_ovf_real,
  output logic               out_ovf_imag,
  output logic [CNT_W-1:0]   out_count
);

`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   accReal_q, accReal_d;
  logic [ACC_W-1:0]   accImag_q, accImag_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovfReal_q, ovfReal_d;
  logic               ovfImag_q, ovfImag_d;
  logic [ACC_W-1:0]   outReal_q, outReal_d;
  logic [ACC_W-1:0]   outImag_q, outImag_d;
  logic [CNT_W-1:0]   outCount_q, outCount_d;
  logic               outOvfReal_q, outOvfReal_d;
  logic               outOvfImag_q, outOvfImag_d;

  logic signed [RES_W-1:0] beatReal, beatImag;
  logic [ACC_W-1:0]        extReal, extImag;
  logic [ACC_W:0]          sumReal, sumImag;
  logic [CNT_W-1:0]        countInc;
  logic                    accept, closeGroup;

  // Returns {overflow, sum}; overflow means equal operand signs but a different result sign.
  function automatic logic [ACC_W:0] addAcc(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] raw;
    logic             ovf;
    raw = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    if (SAT && ovf) begin
      raw = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return {ovf, raw};
  endfunction

  assign beatReal = in_result[2*RES_W-1:RES_W];
  assign beatImag = in_result[RES_W-1:0];
  assign extReal  = ACC_W'(beatReal);
  assign extImag  = ACC_W'(beatImag);
  assign sumReal  = addAcc(accReal_q, extReal);
  assign sumImag  = addAcc(accImag_q, extImag);
  assign countInc = count_q + CNT_W'(1);

  assign in_ready   = (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign accept     = in_valid && in_ready;
  assign closeGroup = accept && ((countInc == CNT_W'(LEN)) || in_last);

  assign out_real     = outReal_q;
  assign out_imag     = outImag_q;
  assign out_count    = outCount_q;
  assign out_ovf_real = outOvfReal_q;
  assign out_ovf_imag = outOvfImag_q;

  // Next-state logic; clear outranks both accept and the output handshake.
  always_comb begin
    state_d      = state_q;
    accReal_d    = accReal_q;
    accImag_d    = accImag_q;
    count_d      = count_q;
    ovfReal_d    = ovfReal_q;
    ovfImag_d    = ovfImag_q;
    outReal_d    = outReal_q;
    outImag_d    = outImag_q;
    outCount_d   = outCount_q;
    outOvfReal_d = outOvfReal_q;
    outOvfImag_d = outOvfImag_q;

    if (clear) begin
      state_d   = IDLE;
      accReal_d = '0;
      accImag_d = '0;
      count_d   = '0;
      ovfReal_d = 1'b0;
      ovfImag_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            accReal_d = sumReal[ACC_W-1:0];
            accImag_d = sumImag[ACC_W-1:0];
            count_d   = countInc;
            ovfReal_d = ovfReal_q | in_ovf_real | sumReal[ACC_W];
            ovfImag_d = ovfImag_q | in_ovf_imag | sumImag[ACC_W];
            if (closeGroup) begin
              state_d      = HOLD;
              outReal_d    = sumReal[ACC_W-1:0];
              outImag_d    = sumImag[ACC_W-1:0];
              outCount_d   = countInc;
              outOvfReal_d = ovfReal_q | in_ovf_real | sumReal[ACC_W];
              outOvfImag_d = ovfImag_q | in_ovf_imag | sumImag[ACC_W];
            end else begin
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d   = IDLE;
            accReal_d = '0;
            accImag_d = '0;
            count_d   = '0;
            ovfReal_d = 1'b0;
            ovfImag_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      accReal_q    <= '0;
      accImag_q    <= '0;
      count_q      <= '0;
      ovfReal_q    <= 1'b0;
      ovfImag_q    <= 1'b0;
      outReal_q    <= '0;
      outImag_q    <= '0;
      outCount_q   <= '0;
      outOvfReal_q <= 1'b0;
      outOvfImag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      accReal_q    <= accReal_d;
      accImag_q    <= accImag_d;
      count_q      <= count_d;
      ovfReal_q    <= ovfReal_d;
      ovfImag_q    <= ovfImag_d;
      outReal_q    <= outReal_d;
      outImag_q    <= outImag_d;
      outCount_q   <= outCount_d;
      outOvfReal_q <= outOvfReal_d;
      outOvfImag_q <= outOvfImag_d;
    end
  end

endmodule

// File: tb/tb_complex_result_accumulator.sv
// Directed bench for complex_result_accumulator: a default instance plus a 12-bit accumulator instance for overflow.
module tb_complex_result_accumulator;

  localparam int RES_W = 11;
  localparam int ACC_W = 16;
  localparam int LEN   = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic reset, clear, in_valid, in_last, in_ovf_real, in_ovf_imag, out_ready;
  logic [2*RES_W-1:0] in_result;

  logic               in_ready, out_valid, out_ovf_real, out_ovf_imag;
  logic [ACC_W-1:0]   out_real, out_imag;
  logic [CNT_W-1:0]   out_count;

  logic               in_ready12, out_valid12, out_ovf_real12, out_ovf_imag12;
  logic [11:0]        out_real12, out_imag12;
  logic [CNT_W-1:0]   out_count12;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  complex_result_accumulator #(.RES_W(RES_W), .ACC_W(ACC_W), .LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_ovf_real(in_ovf_real), .in_ovf_imag(in_ovf_imag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .out_ovf_real(out_ovf_real), .out_ovf_imag(out_ovf_imag), .out_count(out_count)
  );

  complex_result_accumulator #(.RES_W(RES_W), .ACC_W(12), .LEN(LEN), .CNT_W(CNT_W)) dut12 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready12), .in_result(in_result),
    .in_ovf_real(in_ovf_real), .in_ovf_imag(in_ovf_imag), .in_last(in_last),
    .out_valid(out_valid12), .out_ready(out_ready),
    .out_real(out_real12), .out_imag(out_imag12),
    .out_ovf_real(out_ovf_real12), .out_ovf_imag(out_ovf_imag12), .out_count(out_count12)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat for a single edge, then returns the inputs to idle.
  task automatic beat(input int re, input int im, input logic last, input logic ovr, input logic ovi);
    in_result   = {RES_W'(re), RES_W'(im)};
    in_valid    = 1'b1;
    in_last     = last;
    in_ovf_real = ovr;
    in_ovf_imag = ovi;
    tick();
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_ovf_real = 1'b0;
    in_ovf_imag = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++;
    if ({out_real, out_imag} !== 32'h0) $display("[TB] FAIL reset_sums got %h/%h want 0/0", out_real, out_imag); else passed++;
    total++;
    if ({out_count, out_ovf_real, out_ovf_imag} !== 5'b0) $display("[TB] FAIL reset_count_flags got %0d %b%b want 0 00", out_count, out_ovf_real, out_ovf_imag); else passed++;
  endtask

  task automatic test_four_beats();
    out_ready = 1'b1;
    beat(114, 2, 1'b0, 1'b0, 1'b0);
    beat(-64, -50, 1'b0, 1'b0, 1'b0);
    beat(1, 1, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0) $display("[TB] FAIL four_early_valid got %b want 0", out_valid); else passed++;
    beat(0, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1) $display("[TB] FAIL four_valid got %b want 1", out_valid); else passed++;
    total++;
    if (out_real !== 16'(51)) $display("[TB] FAIL four_real got %0d want 51", $signed(out_real)); else passed++;
    total++;
    if (out_imag !== 16'(-47)) $display("[TB] FAIL four_imag got %0d want -47", $signed(out_imag)); else passed++;
    total++;
    if (out_count !== 3'd4) $display("[TB] FAIL four_count got %0d want 4", out_count); else passed++;
    total++;
    if ({out_ovf_real, out_ovf_imag} !== 2'b00) $display("[TB] FAIL four_flags got %b%b want 00", out_ovf_real, out_ovf_imag); else passed++;
    tick();
    total++;
    if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL four_after_handshake got valid=%b ready=%b want 0 1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_in_last();
    out_ready = 1'b1;
    beat(114, 2, 1'b0, 1'b0, 1'b0);
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("[TB] FAIL last_without_valid got %b want 0", out_valid); else passed++;
    beat(-64, -50, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1) $display("[TB] FAIL last_valid got %b want 1", out_valid); else passed++;
    total++;
    if ({out_real, out_imag} !== {16'(50), 16'(-48)}) $display("[TB] FAIL last_sums got %0d/%0d want 50/-48", $signed(out_real), $signed(out_imag)); else passed++;
    total++;
    if (out_count !== 3'd2) $display("[TB] FAIL last_count got %0d want 2", out_count); else passed++;
    tick();
  endtask

  task automatic test_hold_backpressure();
    out_ready = 1'b0;
    beat(10, 20, 1'b0, 1'b0, 1'b0);
    beat(-3, 4, 1'b1, 1'b0, 1'b0);
    in_result = {RES_W'(100), RES_W'(100)};
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({out_valid, in_ready} !== 2'b10) $display("[TB] FAIL hold_handshake cycle %0d got valid=%b ready=%b want 1 0", i, out_valid, in_ready); else passed++;
      total++;
      if ({out_real, out_imag, out_count} !== {16'(7), 16'(24), 3'd2}) $display("[TB] FAIL hold_stable cycle %0d got %0d/%0d/%0d want 7/24/2", i, $signed(out_real), $signed(out_imag), out_count); else passed++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL hold_release got valid=%b ready=%b want 0 1", out_valid, in_ready); else passed++;
    beat(5, -7, 1'b1, 1'b0, 1'b0);
    total++;
    if ({out_real, out_imag, out_count} !== {16'(5), 16'(-7), 3'd1}) $display("[TB] FAIL hold_fresh_group got %0d/%0d/%0d want 5/-7/1", $signed(out_real), $signed(out_imag), out_count); else passed++;
    tick();
  endtask

  task automatic test_overflow();
    logic [11:0] expReal12;
`ifdef SATURATE_EN
    expReal12 = 12'(2047);
`else
    expReal12 = 12'(-4);
`endif
    out_ready = 1'b1;
    beat(1023, 0, 1'b0, 1'b0, 1'b0);
    beat(1023, 0, 1'b0, 1'b0, 1'b0);
    beat(1023, 0, 1'b0, 1'b0, 1'b1);
    beat(1023, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_real12 !== expReal12) $display("[TB] FAIL ovf12_real got %0d want %0d", $signed(out_real12), $signed(expReal12)); else passed++;
    total++;
    if ({out_ovf_real12, out_ovf_imag12, out_valid12} !== 3'b111) $display("[TB] FAIL ovf12_flags got %b%b valid=%b want 11 1", out_ovf_real12, out_ovf_imag12, out_valid12); else passed++;
    total++;
    if (out_real !== 16'(4092)) $display("[TB] FAIL ovf16_real got %0d want 4092", $signed(out_real)); else passed++;
    total++;
    if ({out_ovf_real, out_ovf_imag} !== 2'b01) $display("[TB] FAIL ovf16_flags got %b%b want 01", out_ovf_real, out_ovf_imag); else passed++;
    tick();
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    beat(100, 100, 1'b0, 1'b1, 1'b0);
    beat(100, 100, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    beat(50, 50, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL clear_mid got valid=%b ready=%b want 0 1", out_valid, in_ready); else passed++;
    for (int i = 0; i < 4; i++) beat(1, 1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({out_valid, out_real, out_imag, out_count} !== {1'b1, 16'(4), 16'(4), 3'd4}) $display("[TB] FAIL clear_regroup got valid=%b %0d/%0d/%0d want 1 4/4/4", out_valid, $signed(out_real), $signed(out_imag), out_count); else passed++;
    total++;
    if ({out_ovf_real, out_ovf_imag} !== 2'b00) $display("[TB] FAIL clear_flags got %b%b want 00", out_ovf_real, out_ovf_imag); else passed++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL clear_hold got valid=%b ready=%b want 0 1", out_valid, in_ready); else passed++;
    total++;
    if (out_real !== 16'(4)) $display("[TB] FAIL clear_keeps_out got %0d want 4", $signed(out_real)); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    beat(9, 9, 1'b1, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1) $display("[TB] FAIL rstmid_prehold got %b want 1", out_valid); else passed++;
    reset = 1'b1;
    #2;
    total++;
    if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL rstmid_handshake got valid=%b ready=%b want 0 1", out_valid, in_ready); else passed++;
    total++;
    if ({out_real, out_imag, out_count, out_ovf_real, out_ovf_imag} !== '0) $display("[TB] FAIL rstmid_outputs got %0d/%0d/%0d %b%b want 0", $signed(out_real), $signed(out_imag), out_count, out_ovf_real, out_ovf_imag); else passed++;
    tick();
    reset = 1'b0;
    beat(2, 3, 1'b1, 1'b0, 1'b0);
    total++;
    if ({out_real, out_imag, out_count} !== {16'(2), 16'(3), 3'd1}) $display("[TB] FAIL rstmid_after got %0d/%0d/%0d want 2/3/1", $signed(out_real), $signed(out_imag), out_count); else passed++;
  endtask

  initial begin
    reset       = 1'b1;
    clear       = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_ovf_real = 1'b0;
    in_ovf_imag = 1'b0;
    in_result   = '0;
    out_ready   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_four_beats();
    test_in_last();
    test_hold_backpressure();
    test_overflow();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/complex_result_accumulator.md
Name: complex_result_accumulator

Overview:
- Downstream stage of complexnumber_computer. Consumes its packed complex `result` and its overflow flags.
- Accumulates a group of results (e.g. complex dot product, sum of products) into wide real/imaginary accumulators.
- Presents the group sum over a valid/ready output handshake to the next consumer (display/UART/memory writer).

Parameters:
- RES_W, 11: width of each component of the incoming result (packed input is 2*RES_W bits).
- ACC_W, 16: width of each accumulator component; must be >= RES_W.
- LEN, 4: maximum beats per group; must be >= 1.
- CNT_W, 3: width of out_count; must satisfy 2^CNT_W > LEN.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous abort of the current group.
- in_valid, input, 1: in_result and flags valid this cycle.
- in_ready, output, 1: block can accept a beat.
- in_result, input, 2*RES_W: {real[2*RES_W-1:RES_W], imag[RES_W-1:0]}, two's complement.
- in_ovf_real, input, 1: upstream real overflow for this beat.
- in_ovf_imag, input, 1: upstream imaginary overflow for this beat.
- in_last, input, 1: this beat closes the group early.
- out_valid, output, 1: group sum available.
- out_ready, input, 1: consumer accepts the sum.
- out_real, output, ACC_W: accumulated real part, signed.
- out_imag, output, ACC_W: accumulated imaginary part, signed.
- out_ovf_real, output, 1: sticky real overflow for the group.
- out_ovf_imag, output, 1: sticky imaginary overflow for the group.
- out_count, output, CNT_W: beats in the emitted group.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port named reset.
- Reset: state IDLE; accumulators, count and sticky flags = 0; out_valid = 0; out_real, out_imag, out_count, out_ovf_* = 0.
- States:
  - IDLE: count == 0.
  - ACCUM: 0 < count < LEN.
  - HOLD: result presented.
- in_ready = 1 in IDLE/ACCUM, 0 in HOLD. It is a registered-state decode and does not combinationally depend on in_valid.
- Accept = in_valid & in_ready.
  - Each component is sign-extended to ACC_W and added to its accumulator.
  - count increments.
  - Sticky flag |= upstream flag | signed add overflow (operand signs equal, sum sign differs).
- Arithmetic: two's-complement wrap at ACC_W unless SATURATE_EN is defined.
- Group close: an accept where count+1 == LEN or in_last == 1.
  - On the next edge: state -> HOLD, out_valid = 1.
  - out_real/out_imag/out_count/out_ovf_* are registered from the values including the closing beat.
  - Latency: out_valid rises exactly 1 cycle after the closing accept edge.
- HOLD: all outputs stable while out_valid=1 & out_ready=0. in_valid is ignored (no accept).
- Handshake out_valid & out_ready at an edge:
  - Next cycle: out_valid = 0, state IDLE.
  - Accumulators, count and flags cleared. in_ready = 1.
  - One bubble cycle between groups by design.
- out_* keep their last emitted values while out_valid = 0.
- clear = 1 at an edge: state IDLE; accumulators, count, flags and out_valid = 0, regardless of state (including HOLD); any simultaneous beat is discarded. Priority: reset > clear > handshake/accept.
- in_last on a beat with in_valid=0 has no effect.
- LEN=1: every accept closes a group.
- Reset asserted mid-group or in HOLD: immediate return to reset values, no output emitted.

Optional Feature:
- Macro SATURATE_EN.
- Defined: on add overflow the accumulator clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) (sign of the operands). It stays clamped for subsequent same-sign adds; opposite-sign adds proceed normally from the clamped value. The sticky flag is still set.
- Undefined: wrap-around modulo 2^ACC_W, sticky flag set.

Test Plan:
1. Reset pulse mid-simulation -> out_valid=0, in_ready=1, out_real=out_imag=0, out_count=0, flags 0.
2. Defaults, four beats (114,2), (-64,-50), (1,1), (0,0), out_ready=1 -> one cycle after 4th accept: out_valid=1, out_real=51, out_imag=-47, out_count=4, flags 0; next cycle out_valid=0.
3. Beats (114,2) then (-64,-50) with in_last=1 -> out_real=50, out_imag=-48, out_count=2.
4. After a group closes, hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0, no beats absorbed. Then out_ready=1 -> next cycle out_valid=0, in_ready=1, next group starts from 0.
5. ACC_W=12, four beats real=1023, 3rd beat in_ovf_imag=1:
   - Without SATURATE_EN: out_real=-4, out_ovf_real=1, out_ovf_imag=1.
   - With SATURATE_EN: out_real=2047, out_ovf_real=1, out_ovf_imag=1.
6. clear after 2 of 4 beats, then 4 beats of (1,1) -> out_real=4, out_imag=4, out_count=4; clear asserted in HOLD -> out_valid drops next cycle, no handshake needed.
